// File: rtl/nibble_packer_pkg.sv
// Shared constants and FSM encoding for the nibble packer.
package nibble_packer_pkg;

    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned N_DEF      = 4;

    // FILL collects nibbles; HOLD presents a finished word until taken.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Width needed to hold a nibble count in the range 0..n.
    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nibble_packer_if.sv
// Handshake bundle between the nibble source, the packer and the word sink.
interface nibble_packer_if
    import nibble_packer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned N      = N_DEF
);

    localparam int unsigned WORD_W = N * DATA_W;
    localparam int unsigned CNT_W  = count_width(N);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic [WORD_W-1:0] out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_ready;

    // Environment side: supplies nibbles/flush, consumes words.
    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    // Packer side.
    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_count
    );

endinterface

// File: rtl/nibble_packer.sv
// Packs a stream of DATA_W-bit nibbles into N-nibble words, first nibble in
// the least-significant slot; flush emits a partially filled word.
module nibble_packer
    import nibble_packer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned N      = N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    nibble_packer_if.slave   bus
);

    localparam int unsigned CNT_W = count_width(N);
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t                        state;
    logic [CNT_W-1:0]              cnt;
    logic [N-1:0][DATA_W-1:0]      slots;
    logic                          out_valid_q;
    logic [CNT_W-1:0]              out_count_q;

    // Upstream may dequeue whenever the buffer is filling, or when the held
    // word leaves this cycle; independent of in_valid to avoid a loop with
    // the source queue.
    assign bus.in_ready  = (state == FILL) ? 1'b1 : bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = slots;
    assign bus.out_count = out_count_q;

    // Packing FSM: slot writes, word completion, flush and retirement.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            cnt         <= '0;
            slots       <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (bus.in_valid) begin
                        slots[IDX_W'(cnt)] <= bus.in_data;
                        // A flush on the same cycle still includes this nibble.
                        if ((cnt == CNT_W'(N - 1)) || bus.flush) begin
                            state       <= HOLD;
                            out_valid_q <= 1'b1;
                            out_count_q <= cnt + CNT_W'(1);
                            cnt         <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (bus.flush && (cnt != '0)) begin
                        state       <= HOLD;
                        out_valid_q <= 1'b1;
                        out_count_q <= cnt;
                        cnt         <= '0;
                    end
                end
                HOLD: begin
                    // Word and count stay frozen until the sink takes them.
                    if (bus.out_ready) begin
                        state       <= FILL;
                        out_valid_q <= 1'b0;
                        out_count_q <= '0;
                        // Clearing keeps slots above cnt at zero in later words.
                        slots       <= '0;
                        if (bus.in_valid) begin
                            slots[0] <= bus.in_data;
                            cnt      <= CNT_W'(1);
                        end else begin
                            cnt <= '0;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule
